// File: rtl/ctrl_decode_stage_pkg.sv
// Shared definitions for the RV32 control decode stage:
// opcode constants, ALU operation encodings and the decoded-bundle payload.
package ctrl_decode_stage_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned F3_W    = 3;

  localparam logic [OPC_W-1:0] OPC_R     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_I_ALU = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD  = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH= 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL   = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR  = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI   = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } alu_op_e;

  typedef struct packed {
    alu_op_e           alu_op;
    logic              alu_src;
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic              jalr;
    logic              lui;
    logic              auipc;
    logic              illegal;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [F3_W-1:0]   funct3;
    logic              funct7b5;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational RV32 opcode decoder.
// Ports:
//   instr      in   32  instruction word
//   bundle_c   out      decoded control flags plus register/funct fields
//   rs1_used_c out  1   instruction reads rs1
//   rs2_used_c out  1   instruction reads rs2
module ctrl_decoder
  import ctrl_decode_stage_pkg::*;
#(
  parameter int unsigned ENABLE_EXT = 1
) (
  input  logic [INSTR_W-1:0] instr,
  output ctrl_bundle_t       bundle_c,
  output logic               rs1_used_c,
  output logic               rs2_used_c
);

  localparam bit EXT_ON = (ENABLE_EXT != 0);

  // Immediate-only bits never reach the control bundle.
  logic unused_instr_c;
  assign unused_instr_c = ^{instr[31], instr[29:25]};

  // Opcode decode; everything not set below stays 0.
  always_comb begin
    bundle_c          = '0;
    rs1_used_c        = 1'b0;
    rs2_used_c        = 1'b0;
    bundle_c.rd       = instr[11:7];
    bundle_c.rs1      = instr[19:15];
    bundle_c.rs2      = instr[24:20];
    bundle_c.funct3   = instr[14:12];
    bundle_c.funct7b5 = instr[30];
    case (instr[OPC_W-1:0])
      OPC_R: begin
        bundle_c.reg_write = 1'b1;
        bundle_c.alu_op    = ALU_RTYPE;
        rs1_used_c         = 1'b1;
        rs2_used_c         = 1'b1;
      end
      OPC_I_ALU: begin
        bundle_c.alu_src   = 1'b1;
        bundle_c.reg_write = 1'b1;
        bundle_c.alu_op    = ALU_ITYPE;
        rs1_used_c         = 1'b1;
      end
      OPC_LOAD: begin
        bundle_c.alu_src    = 1'b1;
        bundle_c.mem_to_reg = 1'b1;
        bundle_c.reg_write  = 1'b1;
        bundle_c.mem_read   = 1'b1;
        bundle_c.alu_op     = ALU_ADD;
        rs1_used_c          = 1'b1;
      end
      OPC_STORE: begin
        bundle_c.alu_src   = 1'b1;
        bundle_c.mem_write = 1'b1;
        bundle_c.alu_op    = ALU_ADD;
        rs1_used_c         = 1'b1;
        rs2_used_c         = 1'b1;
      end
      OPC_BRANCH: begin
        bundle_c.branch = 1'b1;
        bundle_c.alu_op = ALU_BRANCH;
        rs1_used_c      = 1'b1;
        rs2_used_c      = 1'b1;
      end
      OPC_JAL: begin
        if (EXT_ON) begin
          bundle_c.jump      = 1'b1;
          bundle_c.reg_write = 1'b1;
        end else begin
          bundle_c.illegal = 1'b1;
        end
      end
      OPC_JALR: begin
        if (EXT_ON) begin
          bundle_c.jump      = 1'b1;
          bundle_c.jalr      = 1'b1;
          bundle_c.alu_src   = 1'b1;
          bundle_c.reg_write = 1'b1;
          rs1_used_c         = 1'b1;
        end else begin
          bundle_c.illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        if (EXT_ON) begin
          bundle_c.lui       = 1'b1;
          bundle_c.reg_write = 1'b1;
        end else begin
          bundle_c.illegal = 1'b1;
        end
      end
      OPC_AUIPC: begin
        if (EXT_ON) begin
          bundle_c.auipc     = 1'b1;
          bundle_c.reg_write = 1'b1;
        end else begin
          bundle_c.illegal = 1'b1;
        end
      end
      default: bundle_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Decode stage: combinational decode at the input, DEPTH elastic output
// registers, and a load-use hazard tracker that inserts one bubble.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_instr/in_ready  instruction handshake (in_ready is combinational)
//   flush                    kill all in-flight entries and the hazard tracker
//   out_valid/out_ready      decoded-bundle handshake
//   alu_op .. illegal        control flags of the bundle at the output
//   rd, rs1, rs2, funct3, funct7b5  register/funct fields of the bundle
//   bubble_cnt               saturating count of inserted load-use bubbles
module ctrl_decode_stage
  import ctrl_decode_stage_pkg::*;
#(
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned ENABLE_EXT = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         alu_op,
  output logic               alu_src,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               branch,
  output logic               jump,
  output logic               jalr,
  output logic               lui,
  output logic               auipc,
  output logic               illegal,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   rs1,
  output logic [REG_W-1:0]   rs2,
  output logic [F3_W-1:0]    funct3,
  output logic               funct7b5,
  output logic [CNT_W-1:0]   bubble_cnt
);

  ctrl_bundle_t       dec_c;
  logic               rs1_used_c;
  logic               rs2_used_c;
  logic [DEPTH-1:0]   stg_valid;
  logic [DEPTH-1:0]   stg_en_c;
  ctrl_bundle_t       stg_data [DEPTH];
  logic               hold;
  logic [REG_W-1:0]   held_rd;
  logic               hazard_c;
  logic               accept_c;

  ctrl_decoder #(
    .ENABLE_EXT (ENABLE_EXT)
  ) u_decoder (
    .instr      (in_instr),
    .bundle_c   (dec_c),
    .rs1_used_c (rs1_used_c),
    .rs2_used_c (rs2_used_c)
  );

  // A stage may load if the consumer is taking data or any stage from it to
  // the output is empty (flattened form of the empty-or-downstream-moves chain).
  for (genvar g = 0; g < DEPTH; g++) begin : g_en
    assign stg_en_c[g] = out_ready || !(&stg_valid[DEPTH-1:g]);
  end

  assign hazard_c = hold && in_valid &&
                    ((rs1_used_c && (dec_c.rs1 == held_rd)) ||
                     (rs2_used_c && (dec_c.rs2 == held_rd)));
  assign in_ready = stg_en_c[0] && !hazard_c;
  assign accept_c = in_valid && in_ready;

  // Elastic output pipeline; a stalled input leaves a bubble in stage 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid <= '0;
      for (int i = 0; i < int'(DEPTH); i++) stg_data[i] <= '0;
    end else begin
      if (stg_en_c[0]) begin
        stg_valid[0] <= accept_c;
        stg_data[0]  <= dec_c;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (stg_en_c[i]) begin
          stg_valid[i] <= stg_valid[i-1];
          stg_data[i]  <= stg_data[i-1];
        end
      end
      if (flush) stg_valid <= '0;
    end
  end

  // Load-use tracker: remembers the rd of the last accepted load.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold    <= 1'b0;
      held_rd <= '0;
    end else begin
      if (accept_c) begin
        hold <= dec_c.mem_read && (dec_c.rd != '0);
        if (dec_c.mem_read) held_rd <= dec_c.rd;
      end else if (hazard_c) begin
        hold <= 1'b0;
      end
      if (flush) hold <= 1'b0;
    end
  end

  // Saturating bubble counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (hazard_c && !(&bubble_cnt)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign out_valid  = stg_valid[DEPTH-1];
  assign alu_op     = stg_data[DEPTH-1].alu_op;
  assign alu_src    = stg_data[DEPTH-1].alu_src;
  assign mem_to_reg = stg_data[DEPTH-1].mem_to_reg;
  assign reg_write  = stg_data[DEPTH-1].reg_write;
  assign mem_read   = stg_data[DEPTH-1].mem_read;
  assign mem_write  = stg_data[DEPTH-1].mem_write;
  assign branch     = stg_data[DEPTH-1].branch;
  assign jump       = stg_data[DEPTH-1].jump;
  assign jalr       = stg_data[DEPTH-1].jalr;
  assign lui        = stg_data[DEPTH-1].lui;
  assign auipc      = stg_data[DEPTH-1].auipc;
  assign illegal    = stg_data[DEPTH-1].illegal;
  assign rd         = stg_data[DEPTH-1].rd;
  assign rs1        = stg_data[DEPTH-1].rs1;
  assign rs2        = stg_data[DEPTH-1].rs2;
  assign funct3     = stg_data[DEPTH-1].funct3;
  assign funct7b5   = stg_data[DEPTH-1].funct7b5;

endmodule

// File: doc/ctrl_decode_stage.md
CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

Interface
REQ-001 Parameter: DEPTH, default 1, number of output register stages (1..4).
REQ-002 Parameter: ENABLE_EXT, default 1; 1 = JAL/JALR/LUI/AUIPC decoded, 0 = those opcodes are illegal.
REQ-003 Parameter: CNT_W, default 16, width of the bubble counter.
REQ-004 One clock and one synchronous, active-high reset.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  instruction word present.
REQ-008 in_instr  in  32  RV32 instruction word.
REQ-009 in_ready  out  1  instruction accepted when in_valid && in_ready.
REQ-010 flush  in  1  kill all in-flight entries and the hazard tracker.
REQ-011 out_valid  out  1  decoded bundle present.
REQ-012 out_ready  in  1  consumer accepts the bundle.
REQ-013 alu_op  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct.
REQ-014 alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, jalr, lui, auipc, illegal  out  1 each  control flags.
REQ-015 rd, rs1, rs2  out  5 each  register fields, passed through.
REQ-016 funct3  out  3  instr[14:12], passed through.
REQ-017 funct7b5  out  1  instr[30], passed through.
REQ-018 bubble_cnt  out  CNT_W  count of inserted load-use bubbles, saturating.

Function
REQ-019 Decode shall be combinational on in_instr[6:0]; every flag not listed for an opcode is 0, never X.
- 0110011 R: reg_write, alu_op=10.
- 0010011 I-ALU: alu_src, reg_write, alu_op=11.
- 0000011 load: alu_src, mem_to_reg, reg_write, mem_read, alu_op=00.
- 0100011 store: alu_src, mem_write, alu_op=00.
- 1100011 branch: branch, alu_op=01.
- 1101111 JAL: jump, reg_write.
- 1100111 JALR: jump, jalr, alu_src, reg_write.
- 0110111 LUI: lui, reg_write.
- 0010111 AUIPC: auipc, reg_write.
REQ-020 Any other opcode, or an extended opcode with ENABLE_EXT=0, shall set illegal=1 with all other control flags 0; field pass-through is unchanged.
REQ-021 The decoded bundle shall pass through DEPTH registered stages; with out_ready held at 1, out_valid follows an accepted instruction by exactly DEPTH cycles.
REQ-022 Each stage shall load when it is empty or when its downstream stage is loading or being consumed; it shall hold otherwise. Bubbles collapse, so full throughput is one instruction per cycle.
REQ-023 Outputs shall be stable while out_valid=1 and out_ready=0.
REQ-024 in_ready = (stage 1 able to load) && !hazard.
REQ-025 Load-use hazard tracking:
- On acceptance of a load with rd!=0, the tracker shall store rd and set hold=1.
- Any other acceptance shall clear hold.
REQ-026 hazard = hold && in_valid && ((rs1 used && rs1==held rd) || (rs2 used && rs2==held rd)).
- rs1 used by R, I-ALU, load, store, branch, JALR.
- rs2 used by R, store, branch.
REQ-027 When hazard=1, in_ready shall be 0 for exactly one cycle. That cycle shall clear hold, inject a bubble (no stage-1 load from input), and increment bubble_cnt, saturating at all-ones.
REQ-028 flush shall clear every stage valid and hold in the same edge; in_ready in the flush cycle is still computed normally, but any handshake in that cycle shall be discarded.
REQ-029 When the pipeline is full and out_ready=0, in_ready shall be 0.

Reset
REQ-030 rst shall clear all stage valids, hold, and bubble_cnt.
REQ-031 After rst: out_valid=0 and all control outputs 0; in_ready=1 in the first cycle after rst deasserts.
REQ-032 rst asserted mid-operation shall discard all in-flight instructions with no out_valid pulse.

Structure
REQ-033 A shared package shall hold the opcode constants, the alu_op encodings, and the decoded-bundle struct typedef.
REQ-034 The combinational decoder shall be one sub-module, ctrl_decoder, instantiated once at the input.

Verification
REQ-035 DEPTH=2, out_ready=1, inputs 0x00208033 (add) then 0x00302083 (lw x1): out_valid at cycles +2 and +3.
- add: reg_write=1, alu_op=10.
- lw: mem_read=1, mem_to_reg=1.
REQ-036 lw x5,0(x1) followed by add x6,x5,x2: in_ready=0 for exactly one cycle, bubble_cnt goes 0→1, add emerges one cycle later than unstalled.
REQ-037 Pipeline full with out_ready=0 for 5 cycles: in_ready=0 and outputs stable; releasing out_ready drains in order.
REQ-038 ENABLE_EXT=0 with JAL 0x0000006F gives illegal=1, jump=0; opcode 0x7F gives illegal=1 in both configurations.
REQ-039 flush with 2 valid stages: out_valid=0 next cycle and hold cleared, so a dependent add after flush sees no bubble.
REQ-040 CNT_W=2 with 5 load-use pairs: bubble_cnt saturates at 3.
